cla_seq_adder: RTL and testbench



---
 rtl/cla_seq_adder.sv | 133 +++++++++++++
 tb/tb_cla_seq_adder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// Multi-cycle add/subtract built around a single 4-bit carry look-ahead
// slice. One nibble is processed per clock, LSB nibble first, with the
// carry held in a register between nibbles.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an operation, in_ready=1
// RUN   | feeding nibble k through the cla, one nibble per clock
// DONE  | result held on sum/cout/ovf, out_valid=1 until out_ready

module cla (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] Sum,
   output logic       Cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   // Generate/propagate terms and flattened look-ahead carries
   always_comb begin
      g    = A & B;
      p    = A ^ B;
      c[0] = Cin;
      c[1] = g[0] | (p[0] & Cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & Cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);
      Sum  = p ^ c[3:0];
      Cout = c[4];
   end

endmodule

module cla_seq_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry;
   logic [CW-1:0]    k;
   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [3:0]       nib_sum;
   logic             nib_cout;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Select the operand nibbles for the current step
   always_comb begin
      a_nib = a_reg[4*k +: 4];
      b_nib = b_reg[4*k +: 4];
   end

   cla u_cla (
      .A    (a_nib),
      .B    (b_nib),
      .Cin  (carry),
      .Sum  (nib_sum),
      .Cout (nib_cout)
   );

   // Sequencer: capture operands, step nibbles, hold result until taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_reg <= '0;
         b_reg <= '0;
         carry <= 1'b0;
         k     <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // subtraction is a + ~b + 1, so invert b and force carry-in
                  a_reg <= a;
                  b_reg <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  k     <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum[4*k +: 4] <= nib_sum;
               carry         <= nib_cout;
               k             <= k + 1'b1;
               if (k == LAST) begin
                  cout  <= nib_cout;
                  ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                           (nib_sum[3] != a_reg[WIDTH-1]);
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: directed cases plus random sweeps at
// WIDTH = 16, 8 and 32, all checked by one negedge compare process
// against an arithmetic reference model.

module tb_cla_seq_adder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   // literal expectation attached to the next main-DUT operation
   bit          lit_en;
   logic [15:0] lit_sum;
   logic        lit_co;
   logic        lit_ovf;
   int          tmo0 = 0;

   int n_tests = 0;
   int n_fail  = 0;

   cla_seq_adder #(.WIDTH(16)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // extra widths, each with its own random driver
   for (genvar gi = 0; gi < 2; gi++) begin : gw
      localparam int W = (gi == 0) ? 8 : 32;
      logic         x_rst, x_iv, x_ir, x_cin, x_sub, x_ov, x_or, x_co, x_ovf;
      logic [W-1:0] x_a, x_b, x_sum;
      int           x_tmo;
      bit           x_done;

      cla_seq_adder #(.WIDTH(W)) u_dut (
         .clk       (clk),
         .rst_n     (x_rst),
         .in_valid  (x_iv),
         .in_ready  (x_ir),
         .a         (x_a),
         .b         (x_b),
         .cin       (x_cin),
         .sub       (x_sub),
         .out_valid (x_ov),
         .out_ready (x_or),
         .sum       (x_sum),
         .cout      (x_co),
         .ovf       (x_ovf)
      );

      initial begin
         bit got;
         x_rst = 1'b0; x_iv = 1'b0; x_a = '0; x_b = '0;
         x_cin = 1'b0; x_sub = 1'b0; x_or = 1'b0; x_tmo = 0; x_done = 1'b0;
         repeat (3) @(posedge clk);
         #1 x_rst = 1'b1;
         @(posedge clk);
         #1;
         for (int n = 0; n < 500; n++) begin
            x_a   = W'($urandom);
            x_b   = W'($urandom);
            if (n % 10 == 0) x_a = '1;
            if (n % 10 == 1) x_b = ~x_a;
            x_cin = 1'($urandom_range(1));
            x_sub = 1'($urandom_range(1));
            x_iv  = 1'b1;
            got   = 1'b0;
            for (int t = 0; t < 40; t++) begin
               @(negedge clk);
               if (x_ir) begin got = 1'b1; break; end
            end
            if (!got) x_tmo++;
            @(posedge clk);
            #1 x_iv = 1'b0;
            x_a = W'($urandom);
            x_b = W'($urandom);
            got = 1'b0;
            for (int t = 0; t < 400; t++) begin
               x_or = ($urandom_range(99) >= 30);
               @(negedge clk);
               if (x_ov && x_or) begin
                  got = 1'b1;
                  @(posedge clk);
                  #1;
                  break;
               end
               @(posedge clk);
               #1;
            end
            if (!got) x_tmo++;
            x_or = 1'b0;
         end
         x_done = 1'b1;
      end
   end

   // Reference: plain integer arithmetic on the operation's meaning
   function automatic void ref_model(input int w, input longint ua, input longint ub,
                                     input bit c, input bit s,
                                     output longint rs, output bit rc, output bit ro);
      longint m, hi, lo, sa, sb, sr, tot;
      m  = (longint'(1) << w) - 1;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -hi - 1;
      sa = (ua > hi) ? ua - (m + 1) : ua;
      sb = (ub > hi) ? ub - (m + 1) : ub;
      if (s) begin
         rs = (ua - ub) & m;
         rc = (ua >= ub);
         sr = sa - sb;
      end else begin
         tot = ua + ub + longint'(c);
         rs  = tot & m;
         rc  = (tot > m);
         sr  = sa + sb + longint'(c);
      end
      ro = (sr > hi) || (sr < lo);
   endfunction

   function automatic void chk(input string nm, input int inst,
                               input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", nm, inst, got, exp);
      end
   endfunction

   function automatic int width_of(input int i);
      return (i == 0) ? 16 : (i == 1) ? 8 : 32;
   endfunction

   // model state, written only by the compare process
   bit     busy[3]     = '{0, 0, 0};
   int     acc[3]      = '{0, 0, 0};
   longint e_sum[3];
   bit     e_co[3];
   bit     e_ovf[3];
   int     tmo_seen[3] = '{0, 0, 0};
   int     cyc         = 0;
   bit     pinned      = 1'b0;
   bit     l_on        = 1'b0;
   logic [15:0] l_sum;
   logic   l_co, l_ovf;
   longint v_a[3], v_b[3], v_sum[3];
   logic   v_rst[3], v_iv[3], v_ir[3], v_ov[3], v_or[3], v_co[3], v_ovf[3];
   logic   v_cin[3], v_sub[3];
   int     v_tmo[3];

   // Compare process: every cycle, every instance
   always @(negedge clk) begin
      longint ps;
      bit     pc, po, exp_ov;
      cyc++;
      if (!pinned) begin
         ref_model(16, 64'h1234, 64'h4321, 1'b0, 1'b0, ps, pc, po);
         chk("pin_add", 0, {ps[62:0], pc, po}, {63'h5555, 1'b0, 1'b0});
         ref_model(16, 64'h8000, 64'h0001, 1'b0, 1'b1, ps, pc, po);
         chk("pin_sub", 0, {ps[62:0], pc, po}, {63'h7FFF, 1'b1, 1'b1});
         ref_model(8, 64'h7F, 64'h01, 1'b0, 1'b0, ps, pc, po);
         chk("pin_w8", 1, {ps[62:0], pc, po}, {63'h80, 1'b0, 1'b1});
         ref_model(32, 64'hFFFFFFFF, 64'h0, 1'b1, 1'b0, ps, pc, po);
         chk("pin_w32", 2, {ps[62:0], pc, po}, {63'h0, 1'b1, 1'b0});
         pinned = 1'b1;
      end
      v_rst[0] = rst_n; v_iv[0] = in_valid; v_ir[0] = in_ready; v_ov[0] = out_valid;
      v_or[0] = out_ready; v_co[0] = cout; v_ovf[0] = ovf; v_cin[0] = cin; v_sub[0] = sub;
      v_a[0] = longint'(a); v_b[0] = longint'(b); v_sum[0] = longint'(sum); v_tmo[0] = tmo0;
      v_rst[1] = gw[0].x_rst; v_iv[1] = gw[0].x_iv; v_ir[1] = gw[0].x_ir; v_ov[1] = gw[0].x_ov;
      v_or[1] = gw[0].x_or; v_co[1] = gw[0].x_co; v_ovf[1] = gw[0].x_ovf;
      v_cin[1] = gw[0].x_cin; v_sub[1] = gw[0].x_sub; v_tmo[1] = gw[0].x_tmo;
      v_a[1] = longint'(gw[0].x_a); v_b[1] = longint'(gw[0].x_b); v_sum[1] = longint'(gw[0].x_sum);
      v_rst[2] = gw[1].x_rst; v_iv[2] = gw[1].x_iv; v_ir[2] = gw[1].x_ir; v_ov[2] = gw[1].x_ov;
      v_or[2] = gw[1].x_or; v_co[2] = gw[1].x_co; v_ovf[2] = gw[1].x_ovf;
      v_cin[2] = gw[1].x_cin; v_sub[2] = gw[1].x_sub; v_tmo[2] = gw[1].x_tmo;
      v_a[2] = longint'(gw[1].x_a); v_b[2] = longint'(gw[1].x_b); v_sum[2] = longint'(gw[1].x_sum);

      for (int i = 0; i < 3; i++) begin
         if (v_tmo[i] != tmo_seen[i]) begin
            tmo_seen[i] = v_tmo[i];
            n_tests++;
            n_fail++;
            $display("FAIL timeout inst%0d: wait bound expired, count %0d, required 0", i, v_tmo[i]);
         end
         if (!v_rst[i]) begin
            busy[i] = 1'b0;
            chk("rst_out_valid", i, 64'(v_ov[i]), 64'd0);
            chk("rst_in_ready", i, 64'(v_ir[i]), 64'd1);
            chk("rst_sum", i, v_sum[i], 64'd0);
            chk("rst_cout_ovf", i, {62'd0, v_co[i], v_ovf[i]}, 64'd0);
         end else begin
            exp_ov = busy[i] && (cyc - acc[i] >= width_of(i) / 4 + 1);
            chk("in_ready", i, 64'(v_ir[i]), 64'(!busy[i]));
            chk("out_valid", i, 64'(v_ov[i]), 64'(exp_ov));
            if (v_ov[i] && exp_ov) begin
               chk("sum", i, v_sum[i], e_sum[i]);
               chk("cout", i, 64'(v_co[i]), 64'(e_co[i]));
               chk("ovf", i, 64'(v_ovf[i]), 64'(e_ovf[i]));
               if (i == 0 && l_on)
                  chk("lit_result", 0, {46'd0, v_sum[0][15:0], v_co[0], v_ovf[0]},
                      {46'd0, l_sum, l_co, l_ovf});
            end
            if (exp_ov && v_or[i]) begin
               busy[i] = 1'b0;
            end else if (!busy[i] && v_iv[i]) begin
               busy[i] = 1'b1;
               acc[i]  = cyc;
               ref_model(width_of(i), v_a[i], v_b[i], v_cin[i], v_sub[i], ps, pc, po);
               e_sum[i] = ps;
               e_co[i]  = pc;
               e_ovf[i] = po;
               if (i == 0) begin
                  l_on = lit_en; l_sum = lit_sum; l_co = lit_co; l_ovf = lit_ovf;
               end
            end
         end
      end
   end

   task automatic setup_op(input logic [15:0] oa, input logic [15:0] ob, input logic oc,
                           input logic os, input bit le, input logic [15:0] ls,
                           input logic lc, input logic lo);
      lit_en = le; lit_sum = ls; lit_co = lc; lit_ovf = lo;
      a = oa; b = ob; cin = oc; sub = os; in_valid = 1'b1;
   endtask

   task automatic wait_accept(input bit keep_valid);
      bit got = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (in_ready) begin got = 1'b1; break; end
      end
      if (!got) tmo0++;
      @(posedge clk);
      #1;
      if (!keep_valid) in_valid = 1'b0;
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom_range(1));
      sub = 1'($urandom_range(1));
   endtask

   task automatic wait_handoff(input int stall_pct);
      bit got = 1'b0;
      for (int t = 0; t < 400; t++) begin
         out_ready = ($urandom_range(99) >= stall_pct);
         @(negedge clk);
         if (out_valid && out_ready) begin
            got = 1'b1;
            @(posedge clk);
            #1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!got) tmo0++;
      out_ready = 1'b0;
   endtask

   task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic oc,
                         input logic os, input bit le, input logic [15:0] ls,
                         input logic lc, input logic lo, input int stall_pct);
      setup_op(oa, ob, oc, os, le, ls, lc, lo);
      wait_accept(1'b0);
      wait_handoff(stall_pct);
   endtask

   initial begin
      bit got;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b0; lit_en = 1'b0; lit_sum = '0; lit_co = 1'b0; lit_ovf = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
      run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 0);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
      run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);

      // backpressure with a new request held the whole time
      setup_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b1, 16'h1010, 1'b0, 1'b0);
      wait_accept(1'b1);
      setup_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
      got = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (out_valid) begin got = 1'b1; break; end
      end
      if (!got) tmo0++;
      repeat (10) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      wait_accept(1'b0);
      wait_handoff(0);

      // asynchronous reset during the second RUN cycle
      setup_op(16'h0ABC, 16'h0123, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      wait_accept(1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      run_op(16'h00F0, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 0);

      for (int n = 0; n < 2000; n++) begin
         run_op(16'($urandom), 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)),
                1'b0, 16'h0, 1'b0, 1'b0, 30);
      end

      got = 1'b0;
      for (int t = 0; t < 30000; t++) begin
         if (gw[0].x_done && gw[1].x_done) begin got = 1'b1; break; end
         @(posedge clk);
      end
      if (!got) tmo0++;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
